// File: rtl/csr_register_bank_if.sv
// CSR bus bundle: the core drives access strobes, address, operand and
// access mode; the selected bank returns read data and a claim flag.
interface csr_register_bank_if;
  logic        csrWriteEnable;
  logic        csrReadEnable;
  logic [11:0] csrAddress;
  logic [31:0] csrWriteData;
  logic [1:0]  csrWriteMode;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;

  modport master (
    output csrWriteEnable,
    output csrReadEnable,
    output csrAddress,
    output csrWriteData,
    output csrWriteMode,
    input  csrReadData,
    input  csrRequestOutput
  );

  modport slave (
    input  csrWriteEnable,
    input  csrReadEnable,
    input  csrAddress,
    input  csrWriteData,
    input  csrWriteMode,
    output csrReadData,
    output csrRequestOutput
  );
endinterface

// File: rtl/csr_register_bank.sv
// Bank of COUNT software-visible CSRs at consecutive addresses. Software
// can write, set or clear bits through a per-bit write mask; hardware can
// load whole registers. Software wins a same-cycle collision on a register.
// A registered change pulse follows every committed software write.
module csr_register_bank #(
  parameter logic [11:0]            ADDRESS     = 12'h000,
  parameter int                     COUNT       = 4,
  parameter int                     WIDTH       = 32,
  parameter logic [COUNT*WIDTH-1:0] WRITE_MASK  = {(COUNT*WIDTH){1'b1}},
  parameter logic [COUNT*WIDTH-1:0] RESET_VALUE = {(COUNT*WIDTH){1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  csr_register_bank_if.slave     bus,
  input  logic [COUNT-1:0]       hwWriteEnable,
  input  logic [COUNT*WIDTH-1:0] hwWriteData,
  output logic [COUNT*WIDTH-1:0] value,
  output logic [COUNT-1:0]       changed
);

  // Decode is done one bit wider than the bus so the window never wraps
  // past the top of the 12-bit CSR space.
  localparam logic [12:0] BASE  = {1'b0, ADDRESS};
  localparam logic [12:0] LIMIT = BASE + 13'(COUNT);

  logic [WIDTH-1:0] regs [COUNT];
  logic [WIDTH-1:0] sw_next [COUNT];
  logic [COUNT-1:0] sw_sel;
  logic [12:0]      addr_wide;
  logic [12:0]      idx;
  logic             hit;
  logic             sw_commit;
  logic [WIDTH-1:0] wr_operand;

  // Combine the current contents with the operand according to the mode.
  function automatic logic [WIDTH-1:0] apply_mode(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] operand,
    input logic [1:0]       mode
  );
    logic [WIDTH-1:0] res;
    case (mode)
      2'b00:   res = operand;
      2'b01:   res = cur | operand;
      2'b10:   res = cur & ~operand;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only software-writable bits take the new value; the rest are kept.
  function automatic logic [WIDTH-1:0] merge_masked(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] upd,
    input logic [WIDTH-1:0] mask
  );
    return (cur & ~mask) | (upd & mask);
  endfunction

  // Address decode and software-write qualification.
  always_comb begin
    addr_wide  = {1'b0, bus.csrAddress};
    hit        = (addr_wide >= BASE) && (addr_wide < LIMIT);
    idx        = addr_wide - BASE;
    sw_commit  = hit && bus.csrWriteEnable && (bus.csrWriteMode != 2'b11);
    wr_operand = WIDTH'(bus.csrWriteData);
  end

  // Per-register software select and the value a software write would commit.
  always_comb begin
    sw_sel = {COUNT{1'b0}};
    for (int i = 0; i < COUNT; i++) begin
      sw_sel[i]  = sw_commit && (idx == 13'(i));
      sw_next[i] = merge_masked(regs[i],
                                apply_mode(regs[i], wr_operand, bus.csrWriteMode),
                                WRITE_MASK[i*WIDTH +: WIDTH]);
    end
  end

  // Combinational read mux; zero and unclaimed when not addressed.
  always_comb begin
    bus.csrReadData      = 32'h0000_0000;
    bus.csrRequestOutput = 1'b0;
    if (hit && bus.csrReadEnable) begin
      bus.csrRequestOutput = 1'b1;
      for (int i = 0; i < COUNT; i++) begin
        if (idx == 13'(i)) begin
          bus.csrReadData = 32'(regs[i]);
        end else begin
          bus.csrReadData = bus.csrReadData;
        end
      end
    end else begin
      bus.csrRequestOutput = 1'b0;
    end
  end

  // Register storage: reset values, software writes over hardware loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COUNT; i++) begin
        regs[i] <= RESET_VALUE[i*WIDTH +: WIDTH];
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        if (sw_sel[i]) begin
          regs[i] <= sw_next[i];
        end else if (hwWriteEnable[i]) begin
          regs[i] <= hwWriteData[i*WIDTH +: WIDTH];
        end else begin
          regs[i] <= regs[i];
        end
      end
    end
  end

  // One-cycle change pulse following each committed software write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      changed <= {COUNT{1'b0}};
    end else begin
      changed <= sw_sel;
    end
  end

  for (genvar g = 0; g < COUNT; g++) begin : g_value
    assign value[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_csr_register_bank.sv
// Self-checking bench for csr_register_bank: directed scenarios followed by
// randomized traffic, all compared against a behavioural register model.
module tb_csr_register_bank;
  localparam logic [11:0] P_ADDR  = 12'h7C0;
  localparam logic [63:0] P_RESET = {16'h0000, 16'hA5A5, 16'h0000, 16'h0000};
  localparam logic [63:0] P_MASK  = {16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF};

  logic        clk;
  logic        rst;
  logic [3:0]  hw_we;
  logic [63:0] hw_wd;
  logic [63:0] value;
  logic [3:0]  changed;

  csr_register_bank_if bus();

  csr_register_bank #(
    .ADDRESS(P_ADDR), .COUNT(4), .WIDTH(16),
    .WRITE_MASK(P_MASK), .RESET_VALUE(P_RESET)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hwWriteEnable(hw_we), .hwWriteData(hw_wd),
    .value(value), .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_reg [4];
  logic [3:0]  m_chg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [11:0] addr,
                       input logic [31:0] data, input logic [1:0] mode,
                       input logic [3:0] hwe, input logic [63:0] hwd);
    bus.csrWriteEnable = we;
    bus.csrReadEnable  = re;
    bus.csrAddress     = addr;
    bus.csrWriteData   = data;
    bus.csrWriteMode   = mode;
    hw_we              = hwe;
    hw_wd              = hwd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h000, 32'h0, 2'b00, 4'h0, 64'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = P_RESET[i*16 +: 16];
    m_chg = 4'h0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_reg%0d", tag, i), {16'h0, value[i*16 +: 16]}, {16'h0, m_reg[i]});
    check({tag, "_changed"}, {28'h0, changed}, {28'h0, m_chg});
  endtask

  // Called at posedge+1 with inputs driven: checks the read path, advances
  // the model by one clock, then checks register contents and pulses.
  task automatic step(input string tag);
    int          idx;
    logic        hit;
    logic        sw;
    logic [15:0] d;
    logic [15:0] nv;
    logic [31:0] exp_rd;
    #3;
    hit = (bus.csrAddress >= P_ADDR) && (bus.csrAddress <= P_ADDR + 12'd3);
    idx = hit ? int'(bus.csrAddress - P_ADDR) : 0;
    exp_rd = (hit && bus.csrReadEnable) ? {16'h0, m_reg[idx]} : 32'h0;
    check({tag, "_rdata"}, bus.csrReadData, exp_rd);
    check({tag, "_rreq"}, {31'h0, bus.csrRequestOutput}, {31'h0, hit && bus.csrReadEnable});
    sw = bus.csrWriteEnable && hit && (bus.csrWriteMode != 2'b11);
    d  = bus.csrWriteData[15:0];
    for (int i = 0; i < 4; i++) begin
      if (sw && i == idx) begin
        case (bus.csrWriteMode)
          2'b00:   nv = d;
          2'b01:   nv = m_reg[i] | d;
          default: nv = m_reg[i] & ~d;
        endcase
        m_reg[i] = (m_reg[i] & ~P_MASK[i*16 +: 16]) | (nv & P_MASK[i*16 +: 16]);
      end else if (hw_we[i]) begin
        m_reg[i] = hw_wd[i*16 +: 16];
      end
    end
    m_chg = sw ? (4'b0001 << idx) : 4'h0;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_state("reset_init");
    rst = 1'b1;

    // Asynchronous reset pulse in mid-cycle restores reg2 immediately.
    drive(1'b0, 1'b0, 12'h000, 32'h0, 2'b00, 4'b0100, {16'h0, 16'h1111, 32'h0});
    step("hw_reg2");
    #2; rst = 1'b0; model_reset(); idle();
    #1;
    check("rst_async_reg2", {16'h0, value[47:32]}, 32'h0000A5A5);
    check_state("rst_async");
    drive(1'b0, 1'b1, 12'h7C2, 32'h0, 2'b00, 4'h0, 64'h0);
    #1;
    check("rst_rd_7c2", bus.csrReadData, 32'h0000A5A5);
    check("rst_req_7c2", {31'h0, bus.csrRequestOutput}, 32'h1);
    bus.csrAddress = 12'h7C4;
    #1;
    check("rst_rd_7c4", bus.csrReadData, 32'h0);
    check("rst_req_7c4", {31'h0, bus.csrRequestOutput}, 32'h0);
    idle();
    #1; rst = 1'b1;
    @(posedge clk); #1;
    step("post_rst");

    // Access modes on reg0.
    drive(1'b1, 1'b0, 12'h7C0, 32'hFFFF1234, 2'b00, 4'h0, 64'h0);
    step("mode_wr");
    check("mode_wr_val", {16'h0, value[15:0]}, 32'h1234);
    check("mode_wr_chg", {28'h0, changed}, 32'h1);
    drive(1'b1, 1'b0, 12'h7C0, 32'h000000F0, 2'b01, 4'h0, 64'h0);
    step("mode_set");
    check("mode_set_val", {16'h0, value[15:0]}, 32'h12F4);
    drive(1'b1, 1'b0, 12'h7C0, 32'h00001004, 2'b10, 4'h0, 64'h0);
    step("mode_clr");
    check("mode_clr_val", {16'h0, value[15:0]}, 32'h02F0);
    drive(1'b1, 1'b0, 12'h7C0, 32'h0000FFFF, 2'b11, 4'h0, 64'h0);
    step("mode_rsv");
    check("mode_rsv_val", {16'h0, value[15:0]}, 32'h02F0);
    check("mode_rsv_chg", {28'h0, changed}, 32'h0);

    // Write mask on reg1, then an unmasked hardware load.
    drive(1'b0, 1'b0, 12'h000, 32'h0, 2'b00, 4'b0010, {32'h0, 16'hAB00, 16'h0});
    step("mask_hw");
    drive(1'b1, 1'b0, 12'h7C1, 32'h0000FFFF, 2'b00, 4'h0, 64'h0);
    step("mask_sw");
    check("mask_sw_val", {16'h0, value[31:16]}, 32'hABFF);
    check("mask_sw_chg", {28'h0, changed}, 32'h2);
    drive(1'b0, 1'b0, 12'h000, 32'h0, 2'b00, 4'b0010, {32'h0, 16'h1234, 16'h0});
    step("mask_hw2");
    check("mask_hw2_val", {16'h0, value[31:16]}, 32'h1234);
    check("mask_hw2_chg", {28'h0, changed}, 32'h0);

    // Collision on reg3; concurrent hardware load on reg2 still lands.
    drive(1'b1, 1'b0, 12'h7C3, 32'h00000001, 2'b00, 4'b1100, {16'hBEEF, 16'hBEEF, 32'h0});
    step("collide");
    check("collide_reg3", {16'h0, value[63:48]}, 32'h0001);
    check("collide_reg2", {16'h0, value[47:32]}, 32'hBEEF);

    // Read during write returns the old value, then the new one.
    drive(1'b1, 1'b1, 12'h7C0, 32'h00005555, 2'b00, 4'h0, 64'h0);
    #3;
    check("rdw_old", bus.csrReadData, 32'h000002F0);
    #(-0);
    @(posedge clk); #1;
    m_reg[0] = 16'h5555; m_chg = 4'h1;
    check_state("rdw");
    drive(1'b0, 1'b1, 12'h7C0, 32'h0, 2'b00, 4'h0, 64'h0);
    #1;
    check("rdw_new", bus.csrReadData, 32'h00005555);
    #(-0);
    step("rdw_next");

    // Randomized traffic around and inside the address window.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'h7BE + 12'($urandom_range(0, 7)), $urandom,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom});
      step("rand");
    end

    // Reset asserted between two back-to-back writes.
    drive(1'b1, 1'b0, 12'h7C0, 32'h0000AAAA, 2'b00, 4'h0, 64'h0);
    step("burst1");
    drive(1'b1, 1'b0, 12'h7C0, 32'h00005555, 2'b00, 4'h0, 64'h0);
    #2; rst = 1'b0; model_reset();
    #1;
    check("burst_rst_reg0", {16'h0, value[15:0]}, 32'h0);
    check("burst_rst_chg", {28'h0, changed}, 32'h0);
    @(posedge clk); #1;
    check_state("burst_held");
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    step("burst_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
